// File: rtl/imem_pkg.sv
// imem_pkg: shared types and helpers for the instruction memory controller.
//   imem_state_t        : controller state (CLEAR, IDLE, LOAD)
//   FILL_INSTR_DEFAULT  : NOP (addi x0,x0,0), used for clear fill and faulted fetches
//   even_parity()       : even parity of a zero-extended data word
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } imem_state_t;

    localparam logic [31:0] FILL_INSTR_DEFAULT = 32'h0000_0013;

    // Widest word the parity helper accepts; callers zero-extend to this width.
    localparam int unsigned PARITY_MAX_W = 64;

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// imem_ram: DEPTH x WIDTH storage, one write port, one registered read port.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port, written on posedge when wr_en=1
//   rd_en/rd_addr       : read request; rd_data updates on the next posedge
//   rd_fill             : with rd_en, load FILL_WORD instead of reading the array
//   rd_data             : registered read data, FILL_WORD after reset
module imem_ram
    import imem_pkg::*;
#(
    parameter int unsigned       DEPTH     = 64,
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  FILL_WORD = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [$clog2(DEPTH)-1:0]  wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    input  logic                      rd_fill,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [WIDTH-1:0]          rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: the array itself is never reset; the clear sequence fills it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: a faulted request returns the fill word without touching the array.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= FILL_WORD;
        end else if (rd_en) begin
            rd_data <= rd_fill ? FILL_WORD : mem[rd_addr];
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: parametrised instruction memory with clear sequencer, streaming
// loader and a one-cycle registered fetch port.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, reported on fetch).
// Ports:
//   clk, reset_n                      : clock, synchronous active-low reset
//   fetch_req/fetch_addr/fetch_ready  : fetch request (byte address), accepted in IDLE
//   fetch_valid/fetch_instr/fetch_fault/parity_err : fetch response, one cycle later
//   load_start/load_base/load_count   : start a load of load_count words at load_base
//   load_valid/load_data/load_ready   : load data stream
//   load_busy/load_done               : loader status, done is a one-cycle pulse
//   parity_inject                     : corrupt stored parity of the current load beat
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned      DEPTH      = 64,
    parameter int unsigned      XLEN       = 32,
    parameter logic [XLEN-1:0]  FILL_INSTR = XLEN'(FILL_INSTR_DEFAULT)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      fetch_req,
    input  logic [XLEN-1:0]           fetch_addr,
    output logic                      fetch_ready,
    output logic                      fetch_valid,
    output logic [XLEN-1:0]           fetch_instr,
    output logic                      fetch_fault,
    input  logic                      load_start,
    input  logic [$clog2(DEPTH)-1:0]  load_base,
    input  logic [$clog2(DEPTH):0]    load_count,
    input  logic                      load_valid,
    input  logic [XLEN-1:0]           load_data,
    output logic                      load_ready,
    output logic                      load_busy,
    output logic                      load_done,
    input  logic                      parity_inject,
    output logic                      parity_err
);

    localparam int unsigned AW = $clog2(DEPTH);

`ifdef IMEM_PARITY_EN
    localparam int unsigned    MW        = XLEN + 1;
    localparam logic [MW-1:0]  FILL_WORD = {even_parity(PARITY_MAX_W'(FILL_INSTR)), FILL_INSTR};
`else
    localparam int unsigned    MW        = XLEN;
    localparam logic [MW-1:0]  FILL_WORD = FILL_INSTR;
`endif

    localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  LAST_PTR  = AW'(DEPTH - 1);

    imem_state_t    state;
    logic [AW-1:0]  ptr;
    logic [AW:0]    remaining;

    logic           fetch_accept_c;
    logic           addr_fault_c;
    logic [AW-1:0]  fetch_index_c;
    logic           load_beat_c;
    logic [AW:0]    count_clamped_c;
    logic           wr_en_c;
    logic [MW-1:0]  wr_word_c;
    logic [MW-1:0]  rd_word;

    assign fetch_accept_c  = fetch_req && fetch_ready;
    assign fetch_index_c   = fetch_addr[AW+1:2];
    // Fault on any misalignment or any set bit above the word index.
    assign addr_fault_c    = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (AW + 2)) != '0);
    assign load_beat_c     = load_valid && load_ready;
    assign count_clamped_c = (load_count > DEPTH_CNT) ? DEPTH_CNT : load_count;
    // Gated by reset_n so an in-flight load beat is dropped when reset arrives.
    assign wr_en_c         = reset_n && ((state == CLEAR) || load_beat_c);

    // Write word: fill pattern while clearing, stream data while loading.
    always_comb begin
        wr_word_c = FILL_WORD;
        if (state == LOAD) begin
`ifdef IMEM_PARITY_EN
            wr_word_c = {even_parity(PARITY_MAX_W'(load_data)) ^ parity_inject, load_data};
`else
            wr_word_c = load_data;
`endif
        end
    end

    // Controller FSM plus registered status/response outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= CLEAR;
            ptr         <= '0;
            remaining   <= '0;
            fetch_ready <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            load_ready  <= 1'b0;
            load_busy   <= 1'b1;
            load_done   <= 1'b0;
        end else begin
            load_done   <= 1'b0;
            fetch_valid <= fetch_accept_c;
            fetch_fault <= fetch_accept_c && addr_fault_c;
            case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_PTR) begin
                        state       <= IDLE;
                        fetch_ready <= 1'b1;
                        load_busy   <= 1'b0;
                    end
                end
                IDLE: begin
                    if (load_start) begin
                        if (count_clamped_c == '0) begin
                            load_done <= 1'b1;
                        end else begin
                            state       <= LOAD;
                            ptr         <= load_base;
                            remaining   <= count_clamped_c;
                            fetch_ready <= 1'b0;
                            load_ready  <= 1'b1;
                            load_busy   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_beat_c) begin
                        ptr       <= ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == (AW+1)'(1)) begin
                            state       <= IDLE;
                            fetch_ready <= 1'b1;
                            load_ready  <= 1'b0;
                            load_busy   <= 1'b0;
                            load_done   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                end
            endcase
        end
    end

    imem_ram #(
        .DEPTH     (DEPTH),
        .WIDTH     (MW),
        .FILL_WORD (FILL_WORD)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en_c),
        .wr_addr (ptr),
        .wr_data (wr_word_c),
        .rd_en   (fetch_accept_c),
        .rd_fill (addr_fault_c),
        .rd_addr (fetch_index_c),
        .rd_data (rd_word)
    );

    assign fetch_instr = rd_word[XLEN-1:0];

`ifdef IMEM_PARITY_EN
    // Faulted responses carry the fill word with correct parity, so no error.
    assign parity_err = fetch_valid && !fetch_fault &&
                        (even_parity(PARITY_MAX_W'(rd_word[XLEN-1:0])) != rd_word[XLEN]);
`else
    logic unused_parity_inject;
    assign unused_parity_inject = parity_inject;
    assign parity_err           = 1'b0;
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
module tb_imem_ctrl;

    localparam int          DEPTH = 64;
    localparam int          AW    = 6;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          PH_CLEAR = 0;
    localparam int          PH_IDLE  = 1;
    localparam int          PH_LOAD  = 2;
`ifdef IMEM_PARITY_EN
    localparam logic        PAR_EN = 1'b1;
`else
    localparam logic        PAR_EN = 1'b0;
`endif

    logic          clk           = 1'b0;
    logic          reset_n       = 1'b0;
    logic          fetch_req     = 1'b0;
    logic [31:0]   fetch_addr    = '0;
    logic          fetch_ready;
    logic          fetch_valid;
    logic [31:0]   fetch_instr;
    logic          fetch_fault;
    logic          load_start    = 1'b0;
    logic [AW-1:0] load_base     = '0;
    logic [AW:0]   load_count    = '0;
    logic          load_valid    = 1'b0;
    logic [31:0]   load_data     = '0;
    logic          load_ready;
    logic          load_busy;
    logic          load_done;
    logic          parity_inject = 1'b0;
    logic          parity_err;

    always #5 clk = ~clk;

    imem_ctrl #(.DEPTH(64), .XLEN(32), .FILL_INSTR(32'h0000_0013)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_ready   (fetch_ready),
        .fetch_valid   (fetch_valid),
        .fetch_instr   (fetch_instr),
        .fetch_fault   (fetch_fault),
        .load_start    (load_start),
        .load_base     (load_base),
        .load_count    (load_count),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .parity_inject (parity_inject),
        .parity_err    (parity_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem     [DEPTH];
    logic        m_par_bad [DEPTH];
    int          m_phase   = PH_CLEAR;
    int          m_cleared = 0;
    int          m_addr    = 0;
    int          m_left    = 0;
    logic        m_valid   = 1'b0;
    logic        m_fault   = 1'b0;
    logic        m_perr    = 1'b0;
    logic        m_done    = 1'b0;
    logic [31:0] m_instr   = NOP;
    logic        cmp_en    = 1'b0;

    always @(posedge clk) begin
        int cnt;
        logic [AW-1:0] widx;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_perr  = 1'b0;
        m_done  = 1'b0;
        if (!reset_n) begin
            m_phase   = PH_CLEAR;
            m_cleared = 0;
        end else begin
            // Fetch sees memory as it was before this edge's write.
            if (m_phase == PH_IDLE && fetch_req) begin
                m_valid = 1'b1;
                if ((fetch_addr % 32'd4) != 0 || fetch_addr >= 32'(DEPTH * 4)) begin
                    m_fault = 1'b1;
                    m_instr = NOP;
                end else begin
                    widx    = AW'(fetch_addr / 32'd4);
                    m_instr = m_mem[widx];
                    m_perr  = m_par_bad[widx];
                end
            end
            case (m_phase)
                PH_CLEAR: begin
                    m_mem[AW'(m_cleared)]     = NOP;
                    m_par_bad[AW'(m_cleared)] = 1'b0;
                    m_cleared++;
                    if (m_cleared == DEPTH) m_phase = PH_IDLE;
                end
                PH_IDLE: begin
                    if (load_start) begin
                        cnt = (int'(load_count) > DEPTH) ? DEPTH : int'(load_count);
                        if (cnt == 0) begin
                            m_done = 1'b1;
                        end else begin
                            m_phase = PH_LOAD;
                            m_addr  = int'(load_base);
                            m_left  = cnt;
                        end
                    end
                end
                default: begin
                    if (load_valid) begin
                        m_mem[AW'(m_addr)]     = load_data;
                        m_par_bad[AW'(m_addr)] = PAR_EN & parity_inject;
                        m_addr = (m_addr + 1) % DEPTH;
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = PH_IDLE;
                            m_done  = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Per-cycle compare of all DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_fetch_ready", 64'(fetch_ready), 64'(m_phase == PH_IDLE));
            check("m_load_ready",  64'(load_ready),  64'(m_phase == PH_LOAD));
            check("m_load_busy",   64'(load_busy),   64'(m_phase != PH_IDLE));
            check("m_load_done",   64'(load_done),   64'(m_done));
            check("m_fetch_valid", 64'(fetch_valid), 64'(m_valid));
            check("m_parity_err",  64'(parity_err),  64'(m_valid & m_perr));
            if (m_valid) begin
                check("m_fetch_instr", 64'(fetch_instr), 64'(m_instr));
                check("m_fetch_fault", 64'(fetch_fault), 64'(m_fault));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] ld_buf  [64];
    logic        inj_buf [64];
    logic        start_valid;
    logic [31:0] start_instr;

    task automatic fetch_check(input string name, input logic [31:0] addr,
                               input logic [31:0] exp_instr, input logic exp_fault,
                               input logic exp_perr);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        @(posedge clk); #1;
        fetch_req  = 1'b0;
        check({name, "_valid"}, 64'(fetch_valid), 64'd1);
        check({name, "_instr"}, 64'(fetch_instr), 64'(exp_instr));
        check({name, "_fault"}, 64'(fetch_fault), 64'(exp_fault));
        check({name, "_perr"},  64'(parity_err),  64'(exp_perr));
    endtask

    // Start a load, then push nbeats words from ld_buf (optional idle gap before even beats).
    task automatic do_load(input logic [AW-1:0] base, input logic [AW:0] count,
                           input int nbeats, input bit gaps);
        load_start = 1'b1;
        load_base  = base;
        load_count = count;
        @(posedge clk); #1;
        load_start  = 1'b0;
        fetch_req   = 1'b0;
        start_valid = fetch_valid;
        start_instr = fetch_instr;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && (i % 2 == 0)) begin
                load_valid = 1'b0;
                @(posedge clk); #1;
            end
            load_valid    = 1'b1;
            load_data     = ld_buf[i];
            parity_inject = inj_buf[i];
            @(posedge clk); #1;
        end
        load_valid    = 1'b0;
        parity_inject = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int limit, output int edges);
        edges = 0;
        while (!fetch_ready && edges < limit) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!fetch_ready) check({name, "_timeout"}, 64'(fetch_ready), 64'd1);
    endtask

    initial begin
        int edges;
        for (int i = 0; i < 64; i++) inj_buf[i] = 1'b0;

        // Reset values
        @(posedge clk); @(posedge clk); #1;
        cmp_en = 1'b1;
        check("rst_fetch_ready", 64'(fetch_ready), 64'd0);
        check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        check("rst_fetch_fault", 64'(fetch_fault), 64'd0);
        check("rst_fetch_instr", 64'(fetch_instr), 64'(NOP));
        check("rst_load_ready",  64'(load_ready),  64'd0);
        check("rst_load_busy",   64'(load_busy),   64'd1);
        check("rst_load_done",   64'(load_done),   64'd0);
        check("rst_parity_err",  64'(parity_err),  64'd0);

        // Clear sequence: ready rises on edge 64 after release
        reset_n = 1'b1;
        wait_ready("clear", 200, edges);
        check("clear_edges", 64'(edges), 64'd64);

        // Back-to-back fetches after clear
        fetch_req  = 1'b1;
        fetch_addr = 32'h000;
        @(posedge clk); #1;
        fetch_addr = 32'h0FC;
        check("b2b0_valid", 64'(fetch_valid), 64'd1);
        check("b2b0_instr", 64'(fetch_instr), 64'(NOP));
        @(posedge clk); #1;
        fetch_req = 1'b0;
        check("b2b1_valid", 64'(fetch_valid), 64'd1);
        check("b2b1_instr", 64'(fetch_instr), 64'(NOP));
        check("b2b1_fault", 64'(fetch_fault), 64'd0);

        // Three-word load with valid gaps
        ld_buf[0] = 32'h0050_0113; ld_buf[1] = 32'h00C0_0193; ld_buf[2] = 32'hFF71_8393;
        do_load(6'd0, 7'd3, 3, 1'b1);
        check("ld1_done",       64'(load_done),  64'd1);
        check("ld1_done_ready", 64'(load_ready), 64'd0);
        @(posedge clk); #1;
        check("ld1_done_clr",   64'(load_done),  64'd0);
        fetch_check("ld1_w1", 32'h004, 32'h00C0_0193, 1'b0, 1'b0);
        fetch_check("ld1_w0", 32'h000, 32'h0050_0113, 1'b0, 1'b0);
        fetch_check("ld1_w2", 32'h008, 32'hFF71_8393, 1'b0, 1'b0);

        // Wrapping load 62,63,0,1
        ld_buf[0] = 32'h1111_1111; ld_buf[1] = 32'h2222_2222;
        ld_buf[2] = 32'h3333_3333; ld_buf[3] = 32'h4444_4444;
        do_load(6'd62, 7'd4, 4, 1'b0);
        check("wrap_done", 64'(load_done), 64'd1);
        fetch_check("wrap_w62", 32'h0F8, 32'h1111_1111, 1'b0, 1'b0);
        fetch_check("wrap_w63", 32'h0FC, 32'h2222_2222, 1'b0, 1'b0);
        fetch_check("wrap_w0",  32'h000, 32'h3333_3333, 1'b0, 1'b0);
        fetch_check("wrap_w1",  32'h004, 32'h4444_4444, 1'b0, 1'b0);
        fetch_check("wrap_w2",  32'h008, 32'hFF71_8393, 1'b0, 1'b0);
        fetch_check("wrap_w3",  32'h00C, NOP,           1'b0, 1'b0);

        // Faulted fetches
        fetch_check("f_mis",  32'h102,      NOP, 1'b1, 1'b0);
        fetch_check("f_oor",  32'h100,      NOP, 1'b1, 1'b0);
        fetch_check("f_byte", 32'h001,      NOP, 1'b1, 1'b0);
        fetch_check("f_top",  32'hFFFF_FFFC, NOP, 1'b1, 1'b0);

        // Zero-count start, with a stray load_valid in IDLE
        load_start = 1'b1; load_count = 7'd0; load_base = 6'd3;
        load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        load_start = 1'b0; load_valid = 1'b0;
        check("zc_done",  64'(load_done),   64'd1);
        check("zc_ready", 64'(fetch_ready), 64'd1);
        check("zc_busy",  64'(load_busy),   64'd0);
        @(posedge clk); #1;
        check("zc_done_clr", 64'(load_done), 64'd0);
        fetch_check("zc_w3", 32'h00C, NOP, 1'b0, 1'b0);

        // Oversized count clamps to DEPTH; same-cycle fetch reads old word 10
        for (int i = 0; i < 64; i++) ld_buf[i] = 32'hA000_0000 + 32'(i);
        fetch_req = 1'b1; fetch_addr = 32'h028;
        do_load(6'd10, 7'd100, 64, 1'b0);
        check("clamp_start_valid", 64'(start_valid), 64'd1);
        check("clamp_start_instr", 64'(start_instr), 64'(NOP));
        check("clamp_done",        64'(load_done),   64'd1);
        fetch_check("clamp_w10", 32'h028, 32'hA000_0000, 1'b0, 1'b0);
        fetch_check("clamp_w9",  32'h024, 32'hA000_003F, 1'b0, 1'b0);
        fetch_check("clamp_w63", 32'h0FC, 32'hA000_0035, 1'b0, 1'b0);

        // Reset after 2 of 5 beats, source still holding the third
        for (int i = 0; i < 5; i++) ld_buf[i] = 32'h5555_0000 + 32'(i);
        do_load(6'd20, 7'd5, 2, 1'b0);
        load_valid = 1'b1; load_data = ld_buf[2];
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("mid_busy",  64'(load_busy),   64'd1);
        check("mid_ready", 64'(load_ready),  64'd0);
        check("mid_fetch", 64'(fetch_ready), 64'd0);
        load_valid = 1'b0;
        reset_n    = 1'b1;
        wait_ready("reclear", 200, edges);
        check("reclear_edges", 64'(edges), 64'd64);
        fetch_check("mid_w20", 32'h050, NOP, 1'b0, 1'b0);
        fetch_check("mid_w21", 32'h054, NOP, 1'b0, 1'b0);

        // Parity injection on word 5 only
        ld_buf[0] = 32'h1234_5678; inj_buf[0] = 1'b0;
        ld_buf[1] = 32'h0000_0013; inj_buf[1] = 1'b1;
        do_load(6'd4, 7'd2, 2, 1'b0);
        inj_buf[1] = 1'b0;
        fetch_check("par_w5", 32'h014, 32'h0000_0013, 1'b0, PAR_EN);
        fetch_check("par_w4", 32'h010, 32'h1234_5678, 1'b0, 1'b0);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
